iic_rd_seq: RTL and testbench
=============================

IIC_RD_SEQ -- requirements
Module: iic_rd_seq

Interface
REQ-001 Parameter C_FIFO_DEPTH, default 16, number of read bytes buffered (power of two, 2..64).
REQ-002 Parameter C_TIMEOUT, default 262143, cycles allowed per single-byte transaction before abort.
REQ-003 I_clk  in  1  system clock, 50 MHz.
REQ-004 I_rst_n  in  1  asynchronous, active-low reset.
REQ-005 I_start  in  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 I_dev_addr  in  7  7-bit I2C device address, latched at start.
REQ-007 I_base_addr  in  8  first word address, latched at start.
REQ-008 I_len  in  8  byte count, latched at start; 0 encodes 256.
REQ-009 O_busy  out  1  high from accepted start until burst end.
REQ-010 O_done  out  1  one-cycle pulse at burst end (normal or abort).
REQ-011 O_err  out  1  sticky timeout flag; cleared on next accepted start.
REQ-012 O_recv_en  out  1  enable to the downstream single-byte I2C read engine.
REQ-013 O_dev_addr  out  7  device address to the read engine.
REQ-014 O_word_addr  out  8  current word address to the read engine.
REQ-015 I_read_data  in  8  byte from the read engine, valid when I_done_flag high.
REQ-016 I_done_flag  in  1  one-cycle completion pulse from the read engine.
REQ-017 O_data  out  8  FIFO head byte.
REQ-018 O_valid  out  1  FIFO non-empty.
REQ-019 I_ready  in  1  consumer accepts O_data when O_valid and I_ready are both high.

Function
REQ-020 States: IDLE, ISSUE, WAIT, GAP, DONE; encoded in 3 bits.
REQ-021 IDLE: I_start high -> latch inputs, remaining count = I_len (0 -> 256), O_err cleared, go ISSUE; otherwise stay IDLE.
REQ-022 ISSUE: FIFO occupancy < C_FIFO_DEPTH -> O_recv_en high, timeout counter cleared, go WAIT; FIFO full -> stay ISSUE with O_recv_en low.
REQ-023 WAIT: O_recv_en held high; on I_done_flag, push I_read_data into FIFO, decrement remaining count, increment O_word_addr modulo 256 (0xFF wraps to 0x00), go GAP.
REQ-024 GAP: O_recv_en low for exactly one cycle, forcing the read engine back to idle; remaining count 0 -> DONE, else ISSUE.
REQ-025 DONE: O_done pulses one cycle, O_busy falls same cycle, go IDLE.
REQ-026 O_recv_en is low in every state except ISSUE (slot available) and WAIT.
REQ-027 At most one byte is outstanding; the FIFO therefore never overflows, and a push is never dropped.
REQ-028 Simultaneous push and pop leave the occupancy unchanged; pop from empty and push to full are impossible by construction.
REQ-029 O_data/O_valid are registered FIFO outputs; a pushed byte is visible on O_valid the cycle after I_done_flag.
REQ-030 FIFO drains independently of the state machine; a new burst may start while the FIFO is non-empty.
REQ-031 I_start while not IDLE is ignored; latched inputs stay stable for the whole burst.
REQ-032 I_done_flag outside WAIT is ignored.

Reset
REQ-033 Asynchronous reset SHALL force state IDLE, O_busy=0, O_done=0, O_err=0, O_recv_en=0, O_dev_addr=0, O_word_addr=0, FIFO empty (O_valid=0, O_data=0).
REQ-034 Reset mid-burst SHALL discard buffered bytes and the remaining count; no O_done pulse is produced.

Configuration
REQ-035 Macro IIC_RD_SEQ_TIMEOUT_EN defined: in WAIT, counter reaching C_TIMEOUT-1 without I_done_flag -> O_recv_en low, O_err set, go DONE (O_done pulses); bytes already buffered are retained.
REQ-036 Macro IIC_RD_SEQ_TIMEOUT_EN undefined: no counter; WAIT waits indefinitely; O_err tied 0.

Verification
REQ-037 Start dev=0x50, base=0x10, len=4, I_ready=1, engine model returns addr^0xA5 -> O_data 0xB5,0xB4,0xB7,0xB6; single O_done; O_recv_en low exactly one cycle between bytes.
REQ-038 base=0xFE, len=3 -> O_word_addr sequence 0xFE,0xFF,0x00.
REQ-039 I_ready=0, len=20, depth 16 -> 16 bytes buffered, ISSUE stalls with O_recv_en low; raise I_ready -> remaining 4 complete, all 20 bytes in order.
REQ-040 TIMEOUT_EN, engine never pulses done -> after C_TIMEOUT cycles O_err=1, O_done pulse, O_recv_en=0; next start clears O_err.
REQ-041 len=0 -> 256 bytes read, addresses wrap to base.
REQ-042 Assert I_rst_n low in WAIT of byte 3 -> all outputs at reset values; fresh start afterwards completes normally.

Source files
------------

// File: rtl/iic_rd_seq_if.sv
// Signal bundle between the burst read sequencer, its host, the single-byte I2C read
// engine and the byte consumer. Clock and reset are not part of the bundle.
//
//   master : sequencer side (drives the O_* signals, receives the I_* signals)
//   slave  : environment side (host, read engine and consumer)
//
// Host      : I_start, I_dev_addr, I_base_addr, I_len -> O_busy, O_done, O_err
// Engine    : O_recv_en, O_dev_addr, O_word_addr -> I_read_data, I_done_flag
// Consumer  : O_data, O_valid -> I_ready
interface iic_rd_seq_if;
  logic       I_start;
  logic [6:0] I_dev_addr;
  logic [7:0] I_base_addr;
  logic [7:0] I_len;
  logic       O_busy;
  logic       O_done;
  logic       O_err;
  logic       O_recv_en;
  logic [6:0] O_dev_addr;
  logic [7:0] O_word_addr;
  logic [7:0] I_read_data;
  logic       I_done_flag;
  logic [7:0] O_data;
  logic       O_valid;
  logic       I_ready;

  modport master (
    input  I_start, I_dev_addr, I_base_addr, I_len, I_read_data, I_done_flag, I_ready,
    output O_busy, O_done, O_err, O_recv_en, O_dev_addr, O_word_addr, O_data, O_valid
  );

  modport slave (
    output I_start, I_dev_addr, I_base_addr, I_len, I_read_data, I_done_flag, I_ready,
    input  O_busy, O_done, O_err, O_recv_en, O_dev_addr, O_word_addr, O_data, O_valid
  );
endinterface

// File: rtl/iic_rd_seq.sv
// Burst read sequencer: turns one start request into I_len single-byte reads on a
// downstream I2C read engine at consecutive word addresses, buffering the bytes in a
// small FIFO that drains to the consumer independently of the sequencing.
//
// Ports:
//   I_clk    : system clock
//   I_rst_n  : asynchronous active-low reset
//   bus      : iic_rd_seq_if.master (host request/status, engine control, FIFO output)
//
// Parameters:
//   C_FIFO_DEPTH : buffered bytes, power of two in 2..64
//   C_TIMEOUT    : cycles allowed per byte before the burst is aborted
//
// Build option: define IIC_RD_SEQ_TIMEOUT_EN to enable the per-byte timeout and O_err;
// without it WAIT waits indefinitely and O_err is tied low.
module iic_rd_seq #(
  parameter int unsigned C_FIFO_DEPTH = 16,
  parameter int unsigned C_TIMEOUT    = 262143
) (
  input logic          I_clk,
  input logic          I_rst_n,
  iic_rd_seq_if.master bus
);

  localparam int unsigned PtrW = $clog2(C_FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StIssue = 3'd1,
    StWait  = 3'd2,
    StGap   = 3'd3,
    StDone  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [6:0]      dev_addr_q, dev_addr_d;
  logic [7:0]      word_addr_q, word_addr_d;
  logic [8:0]      remain_q, remain_d;
  logic            recv_en;
  logic            push, pop;
  logic            tmo_hit;

  logic [7:0]      mem_q [C_FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            fifo_full;

  assign fifo_full = (cnt_q == CntW'(C_FIFO_DEPTH));
  assign pop       = (cnt_q != '0) && bus.I_ready;

  // Sequencing FSM
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q     <= StIdle;
      dev_addr_q  <= '0;
      word_addr_q <= '0;
      remain_q    <= '0;
    end else begin
      state_q     <= state_d;
      dev_addr_q  <= dev_addr_d;
      word_addr_q <= word_addr_d;
      remain_q    <= remain_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dev_addr_d  = dev_addr_q;
    word_addr_d = word_addr_q;
    remain_d    = remain_q;
    recv_en     = 1'b0;
    push        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.I_start) begin
          dev_addr_d  = bus.I_dev_addr;
          word_addr_d = bus.I_base_addr;
          // A length of zero means a full 256-byte burst.
          remain_d    = {(bus.I_len == 8'd0), bus.I_len};
          state_d     = StIssue;
        end
      end
      StIssue: begin
        // Only issue when the returning byte is guaranteed a FIFO slot.
        if (!fifo_full) begin
          recv_en = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.I_done_flag) begin
          recv_en     = 1'b1;
          push        = 1'b1;
          remain_d    = remain_q - 9'd1;
          word_addr_d = word_addr_q + 8'd1;
          state_d     = StGap;
        end else if (tmo_hit) begin
          state_d = StDone;
        end else begin
          recv_en = 1'b1;
        end
      end
      StGap: begin
        // One low cycle on O_recv_en returns the read engine to idle.
        state_d = (remain_q == 9'd0) ? StDone : StIssue;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

`ifdef IIC_RD_SEQ_TIMEOUT_EN
  localparam int unsigned TmoW = ($clog2(C_TIMEOUT) < 1) ? 1 : $clog2(C_TIMEOUT);

  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            err_q, err_d;

  assign tmo_hit = (tmo_q == TmoW'(C_TIMEOUT - 1));

  always_comb begin
    tmo_d = tmo_q;
    if (state_q == StIssue) begin
      tmo_d = '0;
    end else if ((state_q == StWait) && !tmo_hit) begin
      tmo_d = tmo_q + TmoW'(1);
    end
  end

  always_comb begin
    err_d = err_q;
    if ((state_q == StIdle) && bus.I_start) begin
      err_d = 1'b0;
    end else if ((state_q == StWait) && !bus.I_done_flag && tmo_hit) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign bus.O_err = err_q;
`else
  assign tmo_hit   = 1'b0;
  assign bus.O_err = 1'b0;
`endif

  // Byte FIFO; at most one read is outstanding so a push always has room.
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      for (int i = 0; i < C_FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= bus.I_read_data;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      cnt_q <= cnt_d;
    end
  end

  assign bus.O_busy      = (state_q == StIssue) || (state_q == StWait) || (state_q == StGap);
  assign bus.O_done      = (state_q == StDone);
  assign bus.O_recv_en   = recv_en;
  assign bus.O_dev_addr  = dev_addr_q;
  assign bus.O_word_addr = word_addr_q;
  assign bus.O_data      = mem_q[rd_ptr_q];
  assign bus.O_valid     = (cnt_q != '0);

endmodule

// File: tb/tb_iic_rd_seq.sv
// Self-checking bench for iic_rd_seq: a randomized single-byte read engine model, a
// randomized consumer, and a reference model that predicts the address and data
// streams of each burst from its start parameters.
module tb_iic_rd_seq;
  localparam int unsigned Depth = 16;
  localparam int unsigned Tmo   = 64;

  logic clk = 1'b0;
  logic rst_n;

  always #10 clk = ~clk;

  iic_rd_seq_if u_bus ();

  iic_rd_seq #(
    .C_FIFO_DEPTH(Depth),
    .C_TIMEOUT   (Tmo)
  ) u_dut (
    .I_clk  (clk),
    .I_rst_n(rst_n),
    .bus    (u_bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model state
  logic [7:0]  exp_addr_q[$];
  logic [7:0]  exp_data_q[$];
  logic [7:0]  got_q[$];
  logic [6:0]  exp_dev;
  int unsigned ready_mode;   // 0: always ready, 1: random, 2: never
  bit          eng_mute;
  bit          spurious;
  int unsigned eng_delivered = 0;
  int unsigned done_cnt      = 0;
  int unsigned gap_min, gap_max;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read engine: on O_recv_en, answer after a random latency with addr ^ 0xA5
  initial begin : engine
    bit          active;
    int unsigned lat;
    logic [7:0]  addr;
    active = 1'b0;
    lat    = 0;
    addr   = '0;
    u_bus.I_done_flag = 1'b0;
    u_bus.I_read_data = '0;
    forever begin
      @(negedge clk);
      u_bus.I_done_flag = 1'b0;
      if (!rst_n) begin
        active = 1'b0;
      end else if (spurious) begin
        u_bus.I_done_flag = 1'b1;
        u_bus.I_read_data = 8'h3C;
      end else if (!active) begin
        if (u_bus.O_recv_en && !eng_mute) begin
          active = 1'b1;
          lat    = $urandom_range(1, 6);
          addr   = u_bus.O_word_addr;
          check("dev_addr", 32'(u_bus.O_dev_addr), 32'(exp_dev));
          check("addr_expected", 32'(exp_addr_q.size() != 0), 32'd1);
          if (exp_addr_q.size() != 0) check("word_addr", 32'(addr), 32'(exp_addr_q.pop_front()));
        end
      end else if (!u_bus.O_recv_en) begin
        active = 1'b0;
      end else if (lat > 1) begin
        lat--;
      end else begin
        u_bus.I_done_flag = 1'b1;
        u_bus.I_read_data = addr ^ 8'hA5;
        active = 1'b0;
        eng_delivered++;
      end
    end
  end

  // Consumer and output monitor
  initial begin : consumer
    bit          prev_busy, seen_high;
    int unsigned low_run;
    prev_busy = 1'b0;
    seen_high = 1'b0;
    low_run   = 0;
    gap_min   = 1000;
    gap_max   = 0;
    u_bus.I_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       u_bus.I_ready = 1'b1;
        1:       u_bus.I_ready = (($urandom % 2) == 0);
        default: u_bus.I_ready = 1'b0;
      endcase
      if (rst_n && u_bus.O_valid && u_bus.I_ready) begin
        got_q.push_back(u_bus.O_data);
        check("data_expected", 32'(exp_data_q.size() != 0), 32'd1);
        if (exp_data_q.size() != 0) check("data", 32'(u_bus.O_data), 32'(exp_data_q.pop_front()));
      end
      if (u_bus.O_done) begin
        done_cnt++;
        check("busy_low_with_done", 32'(u_bus.O_busy), 32'd0);
      end
      if (u_bus.O_busy && !prev_busy) begin
        seen_high = 1'b0;
        low_run   = 0;
        gap_min   = 1000;
        gap_max   = 0;
      end
      if (u_bus.O_busy) begin
        if (u_bus.O_recv_en) begin
          if (seen_high && low_run > 0) begin
            if (low_run < gap_min) gap_min = low_run;
            if (low_run > gap_max) gap_max = low_run;
          end
          seen_high = 1'b1;
          low_run   = 0;
        end else if (seen_high) begin
          low_run++;
        end
      end
      prev_busy = u_bus.O_busy;
    end
  end

  task automatic check_reset_outputs();
    check("rst_busy",      32'(u_bus.O_busy),      32'd0);
    check("rst_done",      32'(u_bus.O_done),      32'd0);
    check("rst_err",       32'(u_bus.O_err),       32'd0);
    check("rst_recv_en",   32'(u_bus.O_recv_en),   32'd0);
    check("rst_dev_addr",  32'(u_bus.O_dev_addr),  32'd0);
    check("rst_word_addr", 32'(u_bus.O_word_addr), 32'd0);
    check("rst_valid",     32'(u_bus.O_valid),     32'd0);
    check("rst_data",      32'(u_bus.O_data),      32'd0);
  endtask

  task automatic start_burst(input logic [6:0] dev, input logic [7:0] base,
                             input logic [7:0] len);
    int unsigned n;
    n       = (len == 8'd0) ? 256 : int'(len);
    exp_dev = dev;
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(8'(int'(base) + i));
      exp_data_q.push_back(8'(int'(base) + i) ^ 8'hA5);
    end
    u_bus.I_start     = 1'b1;
    u_bus.I_dev_addr  = dev;
    u_bus.I_base_addr = base;
    u_bus.I_len       = len;
    tick();
    u_bus.I_start     = 1'b0;
    // Scramble the request inputs; the burst must run on the latched copies.
    u_bus.I_dev_addr  = 7'($urandom);
    u_bus.I_base_addr = 8'($urandom);
    u_bus.I_len       = 8'($urandom);
    check("busy_after_start", 32'(u_bus.O_busy), 32'd1);
  endtask

  task automatic end_burst(input int unsigned n, input int unsigned budget, input bit exp_err,
                           input int unsigned d0, input int unsigned e0);
    int unsigned k;
    k = 0;
    while (!u_bus.O_done && k < budget) begin
      tick();
      k++;
    end
    check("done_seen",       32'(u_bus.O_done),    32'd1);
    check("err_at_done",     32'(u_bus.O_err),     32'(exp_err));
    check("recv_en_at_done", 32'(u_bus.O_recv_en), 32'd0);
    tick();
    tick();
    check("done_pulses", done_cnt - d0,      32'd1);
    check("bytes_read",  eng_delivered - e0, exp_err ? 32'd0 : n);
    if (exp_err) begin
      exp_addr_q.delete();
      exp_data_q.delete();
    end
    k = 0;
    while ((u_bus.O_valid || exp_data_q.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    check("drained",     exp_data_q.size(),  32'd0);
    check("valid_empty", 32'(u_bus.O_valid), 32'd0);
    check("addr_q_used", exp_addr_q.size(),  32'd0);
  endtask

  task automatic run_burst(input logic [6:0] dev, input logic [7:0] base, input logic [7:0] len,
                           input int unsigned budget);
    int unsigned d0, e0;
    d0 = done_cnt;
    e0 = eng_delivered;
    start_burst(dev, base, len);
    end_burst((len == 8'd0) ? 256 : int'(len), budget, 1'b0, d0, e0);
  endtask

  initial begin : main
    logic [7:0]  t1_exp [4];
    int unsigned d0, e0, k;
    rst_n             = 1'b0;
    u_bus.I_start     = 1'b0;
    u_bus.I_dev_addr  = '0;
    u_bus.I_base_addr = '0;
    u_bus.I_len       = '0;
    ready_mode        = 0;
    eng_mute          = 1'b0;
    spurious          = 1'b0;
    exp_dev           = '0;
    t1_exp            = '{8'hB5, 8'hB4, 8'hB7, 8'hB6};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    tick();

    // Basic 4-byte burst with an always-ready consumer
    got_q.delete();
    run_burst(7'h50, 8'h10, 8'd4, 400);
    check("gap_min", gap_min, 32'd1);
    check("gap_max", gap_max, 32'd1);
    check("t1_count", got_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) check("t1_byte", 32'(got_q[i]), 32'(t1_exp[i]));
    end

    // Word address wraps 0xFF -> 0x00
    run_burst(7'h2A, 8'hFE, 8'd3, 400);

    // Stalled consumer: FIFO fills, issuing stops until space frees up
    ready_mode = 2;
    got_q.delete();
    d0 = done_cnt;
    e0 = eng_delivered;
    start_burst(7'h33, 8'h40, 8'd20);
    k = 0;
    while ((eng_delivered - e0) < Depth && k < 600) begin
      tick();
      k++;
    end
    repeat (30) tick();
    check("stall_bytes",   eng_delivered - e0,  32'(Depth));
    check("stall_recv_en", 32'(u_bus.O_recv_en), 32'd0);
    check("stall_busy",    32'(u_bus.O_busy),    32'd1);
    check("stall_valid",   32'(u_bus.O_valid),   32'd1);
    ready_mode = 1;
    end_burst(20, 2000, 1'b0, d0, e0);
    check("stall_total", got_q.size(), 32'd20);

    // Length 0 means 256 bytes; the address ends back at the base
    run_burst(7'h11, 8'h80, 8'd0, 8000);
    check("wrap_word_addr", 32'(u_bus.O_word_addr), 32'h80);

    // A done pulse from the engine while idle must be ignored
    spurious = 1'b1;
    tick();
    spurious = 1'b0;
    tick();
    tick();
    check("spurious_valid", 32'(u_bus.O_valid), 32'd0);
    check("spurious_busy",  32'(u_bus.O_busy),  32'd0);

    // Reset asserted while waiting on byte 3
    ready_mode = 0;
    d0 = done_cnt;
    e0 = eng_delivered;
    start_burst(7'h22, 8'h05, 8'd8);
    k = 0;
    while (!((eng_delivered - e0) >= 2 && u_bus.O_recv_en) && k < 200) begin
      tick();
      k++;
    end
    tick();
    check("pre_reset_recv_en", 32'(u_bus.O_recv_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_addr_q.delete();
    exp_data_q.delete();
    repeat (3) tick();
    check("reset_no_done", done_cnt - d0, 32'd0);
    rst_n = 1'b1;
    tick();
    run_burst(7'h22, 8'h05, 8'd8, 400);

    // Random bursts; the first gets a stray start while busy
    for (int b = 0; b < 6; b++) begin
      logic [6:0] dev;
      logic [7:0] base, len;
      ready_mode = $urandom_range(0, 1);
      dev  = 7'($urandom);
      base = 8'($urandom);
      len  = 8'($urandom_range(1, 40));
      if (b == 0) begin
        d0 = done_cnt;
        e0 = eng_delivered;
        start_burst(dev, base, len);
        repeat (3) tick();
        u_bus.I_start     = 1'b1;
        u_bus.I_dev_addr  = ~dev;
        u_bus.I_base_addr = ~base;
        u_bus.I_len       = 8'd1;
        tick();
        u_bus.I_start = 1'b0;
        end_burst(int'(len), 2000, 1'b0, d0, e0);
      end else begin
        run_burst(dev, base, len, 2000);
      end
    end

`ifdef IIC_RD_SEQ_TIMEOUT_EN
    // Engine never answers: abort with O_err, which the next start clears
    ready_mode = 0;
    eng_mute   = 1'b1;
    d0 = done_cnt;
    e0 = eng_delivered;
    start_burst(7'h44, 8'h00, 8'd2);
    end_burst(2, Tmo + 40, 1'b1, d0, e0);
    check("err_sticky", 32'(u_bus.O_err), 32'd1);
    eng_mute = 1'b0;
    d0 = done_cnt;
    e0 = eng_delivered;
    start_burst(7'h44, 8'h00, 8'd2);
    check("err_cleared", 32'(u_bus.O_err), 32'd0);
    end_burst(2, 400, 1'b0, d0, e0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

endmodule
